clock_tick_manager: RTL and testbench

- Parametrised clock-domain manager that runs downstream of the iCE40 PLL.
- Qualifies the PLL `locked` signal and sequences a glitch-free synchronous system reset from it.
- Generates NUM_CH independent, runtime-programmable clock-enable tick streams (UART baud, timers, sampling) using fractional phase accumulators.
- Lets the SoC use one global clock instead of a second PLL output per peripheral.

---
 rtl/clock_tick_manager.sv | 134 +++++++++++++
 tb/tb_clock_tick_manager.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_manager.sv
// PLL lock qualifier, sys_reset sequencer and NUM_CH fractional clock-enable tick generators; lock_s lags locked by 2 cycles, ticks are registered.
// No backpressure: config writes are accepted every cycle in any state, ticks are free-running pulses.
module clock_tick_manager #(
  parameter int                   NUM_CH             = 2,
  parameter int                   ACC_WIDTH          = 24,
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT        = ACC_WIDTH'(201),
  parameter int                   LOCK_STABLE_CYCLES = 1024,
  parameter int                   RST_HOLD_CYCLES    = 16,
  localparam int                  CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 locked,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic [NUM_CH-1:0]    ch_enable,
  output logic [NUM_CH-1:0]    tick,
  output logic                 sys_reset,
  output logic                 ready,
  output logic [7:0]           lock_loss_cnt
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_STABLE = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_HOLD   = CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_meta;
  logic             lock_s;
  logic             ready_nxt;
  logic             lock_lost;

  // locked comes straight from the PLL and is asynchronous to clock_in
  always_ff @(posedge clock_in) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    lock_lost = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s)                 state_nxt = WAIT_LOCK;
        else if (cnt == LAST_STABLE) state_nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)               state_nxt = WAIT_LOCK;
        else if (cnt == LAST_HOLD) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          lock_lost = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    ready_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      sys_reset     <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_reset <= !ready_nxt;
      ready     <= ready_nxt;
      if (lock_lost && (lock_loss_cnt != 8'hFF)) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   sum;
    logic                 wr_hit;
    logic                 tick_r;

    // out-of-range channel indices match no channel, so such writes drop
    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));
    assign sum    = {1'b0, acc} + {1'b0, inc};

    // the tick is gated by the next ready so a lock drop silences it on the state edge
    always_ff @(posedge clock_in) begin
      if (reset) begin
        acc    <= '0;
        inc    <= INC_DEFAULT;
        tick_r <= 1'b0;
      end else begin
        if (wr_hit) inc <= cfg_inc;
        if (ready && ch_enable[i]) begin
          acc    <= sum[ACC_WIDTH-1:0];
          tick_r <= sum[ACC_WIDTH] & ready_nxt;
        end else begin
          acc    <= '0;
          tick_r <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_r;
  end

endmodule

// File: tb/tb_clock_tick_manager.sv
// Directed bench for clock_tick_manager: reset sequencing, lock glitch/loss, tick rates, config writes.
module tb_clock_tick_manager;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, locked;
  logic          cfg_wr;
  logic [0:0]    cfg_ch;
  logic [AW-1:0] cfg_inc;
  logic [1:0]    ch_enable, tick;
  logic          sys_reset, ready;
  logic [7:0]    llc;

  logic          cfg_wr3;
  logic [1:0]    cfg_ch3;
  logic [AW-1:0] cfg_inc3;
  logic [2:0]    ch_enable3, tick3;
  logic          sys_reset3, ready3;
  logic [7:0]    llc3;

  int n_cmp, n_bad, cyc, run3, n;
  int cnt3 [3];

  always #5 clk = ~clk;

  clock_tick_manager #(
    .NUM_CH(2), .ACC_WIDTH(AW), .INC_DEFAULT(8'd201),
    .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(4)
  ) dut (
    .clock_in(clk), .reset(reset), .locked(locked),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .ch_enable(ch_enable), .tick(tick), .sys_reset(sys_reset),
    .ready(ready), .lock_loss_cnt(llc)
  );

  // three channels so that cfg_ch=3 is a representable out-of-range index
  clock_tick_manager #(
    .NUM_CH(3), .ACC_WIDTH(AW), .INC_DEFAULT(8'd201),
    .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(4)
  ) dut3 (
    .clock_in(clk), .reset(reset), .locked(locked),
    .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3), .cfg_inc(cfg_inc3),
    .ch_enable(ch_enable3), .tick(tick3), .sys_reset(sys_reset3),
    .ready(ready3), .lock_loss_cnt(llc3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ready3) begin
      if (run3 >= 1 && run3 <= 256)
        for (int c = 0; c < 3; c++) cnt3[c] += int'(tick3[c]);
      run3++;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; run3 = 0; n = 0;
    for (int c = 0; c < 3; c++) cnt3[c] = 0;
    reset = 1'b1; locked = 1'b1;
    cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_inc = 8'd0; ch_enable = 2'b11;
    cfg_wr3 = 1'b0; cfg_ch3 = 2'd0; cfg_inc3 = 8'd0; ch_enable3 = 3'b111;
    step(); step();
    chk("rst_sys_reset", 32'(sys_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_llc", 32'(llc), 0);

    // clean lock: RUN exactly after edge 15
    reset = 1'b0; cyc = 0;
    repeat (14) step();
    chk("a_sys_reset_e14", 32'(sys_reset), 1);
    chk("a_ready_e14", 32'(ready), 0);
    step();
    chk("a_sys_reset_e15", 32'(sys_reset), 0);
    chk("a_ready_e15", 32'(ready), 1);

    // one-cycle lock glitch during STABLE; writes while sys_reset is high
    reset = 1'b1; step(); reset = 1'b0;
    cyc = 0; run3 = 0;
    for (int c = 0; c < 3; c++) cnt3[c] = 0;
    cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd64;
    cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_inc3 = 8'd0;
    step();
    cfg_ch = 1'b1; cfg_inc = 8'd0; cfg_wr3 = 1'b0;
    step();
    cfg_wr = 1'b0;
    while (cyc < 8) step();
    locked = 1'b0; step(); locked = 1'b1;
    while (cyc < 23) step();
    chk("b_sys_reset_e23", 32'(sys_reset), 1);
    chk("b_ready_e23", 32'(ready), 0);
    step();
    chk("b_sys_reset_e24", 32'(sys_reset), 0);
    chk("b_ready_e24", 32'(ready), 1);

    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("tick_run%0d", k), 32'(tick), (k % 4 == 0) ? 1 : 0);
    end

    // one-cycle channel disable restarts the phase
    step();
    ch_enable[0] = 1'b0; step();
    chk("dis_tick", 32'(tick[0]), 0);
    ch_enable[0] = 1'b1;
    for (int k = 15; k <= 18; k++) begin
      step();
      chk($sformatf("reen_run%0d", k), 32'(tick[0]), (k == 18) ? 1 : 0);
    end

    // write coinciding with a wrap uses the old increment
    repeat (3) step();
    cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd16; step(); cfg_wr = 1'b0;
    chk("wrap_old_inc", 32'(tick[0]), 1);
    n = 0;
    repeat (15) begin step(); n += int'(tick[0]); end
    chk("wrap_gap", 32'(n), 0);
    step();
    chk("wrap_new_inc", 32'(tick[0]), 1);

    // full-scale increment on channel 1
    cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd255; step(); cfg_wr = 1'b0;
    step();
    chk("fs_first", 32'(tick[1]), 0);
    n = 0;
    repeat (255) begin step(); n += int'(tick[1]); end
    chk("fs_count", 32'(n), 255);
    step();
    chk("fs_gap", 32'(tick[1]), 0);
    step();
    chk("fs_resume", 32'(tick[1]), 1);

    for (int c = 0; c < 3; c++) chk($sformatf("oob_ch%0d_ticks", c), 32'(cnt3[c]), 201);

    // lock loss in RUN
    locked = 1'b0; step(); step();
    chk("loss_e2_ready", 32'(ready), 1);
    chk("loss_e2_tick1", 32'(tick[1]), 1);
    chk("loss_e2_llc", 32'(llc), 0);
    step();
    chk("loss_e3_sys_reset", 32'(sys_reset), 1);
    chk("loss_e3_ready", 32'(ready), 0);
    chk("loss_e3_tick", 32'(tick), 0);
    chk("loss_e3_llc", 32'(llc), 1);
    locked = 1'b1;
    repeat (15) step();
    chk("relock_ready", 32'(ready), 1);
    n = 0;
    repeat (15) begin step(); n += int'(tick[0]); end
    chk("relock_gap", 32'(n), 0);
    step();
    chk("relock_first", 32'(tick[0]), 1);

    for (int i = 2; i <= 256; i++) begin
      locked = 1'b0; repeat (3) step();
      locked = 1'b1; repeat (15) step();
      if (i == 2 || i == 255 || i == 256)
        chk($sformatf("llc_after_%0d", i), 32'(llc), (i == 256) ? 255 : i);
    end
    chk("loop_ready", 32'(ready), 1);

    // reset in RUN, then defaults return
    repeat (5) step();
    chk("pre_rst_tick1", 32'(tick[1]), 1);
    reset = 1'b1; step();
    chk("mid_rst_sys_reset", 32'(sys_reset), 1);
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_llc", 32'(llc), 0);
    reset = 1'b0;
    repeat (15) step();
    chk("dflt_ready", 32'(ready), 1);
    step();
    chk("dflt_run1", 32'(tick), 0);
    step();
    chk("dflt_run2", 32'(tick), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
